// File: rtl/jbi_mout_dbg_arb_pkg.sv
// Shared jbi definitions for the mout debug-port arbiter: state encodings,
// default transfer length and CSR field widths.
package jbi_mout_dbg_arb_pkg;

  localparam int unsigned JBI_DBG_LEN_DEFAULT       = 2;
  localparam int unsigned JBI_NORM_LEN_WIDTH        = 3;
  localparam int unsigned JBI_CSR_DBG_PRI_LIM_WIDTH = 4;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StDbgXfer  = 2'd1,
    StNormXfer = 2'd2
  } arb_state_e;

  // Beat counter must hold both DBG_LEN-1 (up to 7) and the normal length field.
  function automatic int unsigned beat_width(int unsigned norm_len_w);
    return (norm_len_w > 3) ? norm_len_w : 3;
  endfunction

endpackage

// File: rtl/jbi_mout_dbg_arb_pick.sv
// Combinational winner selection for the mout JBus slot: debug queue versus
// normal mout traffic, including the priority-run starvation limit.
module jbi_mout_dbg_arb_pick #(
  parameter int unsigned PRI_LIM_W = 4
) (
  input  logic                 dbg_req_transparent,
  input  logic                 dbg_req_arbitrate,
  input  logic                 dbg_req_priority,
  input  logic                 mout_norm_req,
  input  logic                 last_dbg,
  input  logic [PRI_LIM_W-1:0] pri_run,
  input  logic [PRI_LIM_W-1:0] pri_limit,
  output logic                 win_dbg,
  output logic                 win_norm,
  output logic                 pri_win
);

  logic limit_hit;

  // Equality (not >=) so a limit lowered below the live count never matches.
  assign limit_hit = (pri_limit != '0) && (pri_run == pri_limit) && mout_norm_req;

  always_comb begin
    win_dbg  = 1'b0;
    win_norm = 1'b0;
    pri_win  = 1'b0;
    if (dbg_req_priority) begin
      if (!limit_hit) begin
        win_dbg = 1'b1;
        pri_win = 1'b1;
      end else begin
        win_norm = 1'b1;
      end
    end else if (dbg_req_arbitrate && mout_norm_req) begin
      win_dbg  = ~last_dbg;
      win_norm = last_dbg;
    end else if (mout_norm_req) begin
      win_norm = 1'b1;
    end else if (dbg_req_arbitrate || dbg_req_transparent) begin
      win_dbg = 1'b1;
    end
  end

endmodule

// File: rtl/jbi_mout_dbg_arb.sv
// JBus output-slot arbiter for mout: chooses between normal transactions and the
// debug queue, issues pop/grant pulses and sequences multi-cycle transfers.
module jbi_mout_dbg_arb
  import jbi_mout_dbg_arb_pkg::*;
#(
  parameter int unsigned DBG_LEN    = JBI_DBG_LEN_DEFAULT,
  parameter int unsigned NORM_LEN_W = JBI_NORM_LEN_WIDTH,
  parameter int unsigned PRI_LIM_W  = JBI_CSR_DBG_PRI_LIM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  dbg_req_transparent,
  input  logic                  dbg_req_arbitrate,
  input  logic                  dbg_req_priority,
  input  logic                  mout_norm_req,
  input  logic [NORM_LEN_W-1:0] mout_norm_len,
  input  logic                  jbus_slot_avail,
  input  logic [PRI_LIM_W-1:0]  csr_jbi_debug_arb_pri_limit,
  output logic                  mout_dbg_pop,
  output logic                  mout_norm_gnt,
  output logic                  mout_sel_dbg,
  output logic                  mout_sel_norm,
  output logic                  arb_busy
);

  localparam int unsigned BeatW = beat_width(NORM_LEN_W);
  localparam logic [BeatW-1:0] DbgBeats = BeatW'(DBG_LEN - 1);

  arb_state_e           state_q, state_d;
  logic [BeatW-1:0]     beat_cnt_q, beat_cnt_d;
  logic                 last_dbg_q, last_dbg_d;
  logic [PRI_LIM_W-1:0] pri_run_q, pri_run_d;
  logic                 pop_q, pop_d;
  logic                 gnt_q, gnt_d;

  logic win_dbg, win_norm, pri_win;

  jbi_mout_dbg_arb_pick #(
    .PRI_LIM_W (PRI_LIM_W)
  ) u_pick (
    .dbg_req_transparent (dbg_req_transparent),
    .dbg_req_arbitrate   (dbg_req_arbitrate),
    .dbg_req_priority    (dbg_req_priority),
    .mout_norm_req       (mout_norm_req),
    .last_dbg            (last_dbg_q),
    .pri_run             (pri_run_q),
    .pri_limit           (csr_jbi_debug_arb_pri_limit),
    .win_dbg             (win_dbg),
    .win_norm            (win_norm),
    .pri_win             (pri_win)
  );

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    last_dbg_d = last_dbg_q;
    pri_run_d  = pri_run_q;
    pop_d      = 1'b0;
    gnt_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (jbus_slot_avail) begin
          if (win_dbg) begin
            state_d    = StDbgXfer;
            beat_cnt_d = DbgBeats;
            last_dbg_d = 1'b1;
            pop_d      = 1'b1;
          end else if (win_norm) begin
            state_d    = StNormXfer;
            beat_cnt_d = BeatW'(mout_norm_len);
            last_dbg_d = 1'b0;
            gnt_d      = 1'b1;
          end
          // Run length only counts priority wins that actually held off a normal request.
          if (win_norm || !mout_norm_req) begin
            pri_run_d = '0;
          end else if (pri_win && (pri_run_q != '1)) begin
            pri_run_d = pri_run_q + 1'b1;
          end
        end
      end
      StDbgXfer, StNormXfer: begin
        if (beat_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          beat_cnt_d = beat_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      last_dbg_q <= 1'b0;
      pri_run_q  <= '0;
      pop_q      <= 1'b0;
      gnt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      last_dbg_q <= last_dbg_d;
      pri_run_q  <= pri_run_d;
      pop_q      <= pop_d;
      gnt_q      <= gnt_d;
    end
  end

  assign mout_dbg_pop  = pop_q;
  assign mout_norm_gnt = gnt_q;
  assign mout_sel_dbg  = (state_q == StDbgXfer);
  assign mout_sel_norm = (state_q == StNormXfer);
  assign arb_busy      = (state_q != StIdle);

  // Debug requests are expected one-hot; overlaps resolve priority > arbitrate > transparent.
  dbg_req_onehot: assert property (@(posedge clk) disable iff (!rst_l)
    $onehot0({dbg_req_transparent, dbg_req_arbitrate, dbg_req_priority}));

endmodule

// File: tb/tb_jbi_mout_dbg_arb.sv
// Self-checking bench for jbi_mout_dbg_arb: directed scenarios with literal
// expectations plus randomized traffic checked against a transaction-level model.
module tb_jbi_mout_dbg_arb;

  localparam int unsigned DBG_LEN    = 2;
  localparam int unsigned NORM_LEN_W = 3;
  localparam int unsigned PRI_LIM_W  = 4;
  localparam int          PRI_MAX    = (1 << PRI_LIM_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst_l;
  logic                  dbg_req_transparent, dbg_req_arbitrate, dbg_req_priority;
  logic                  mout_norm_req;
  logic [NORM_LEN_W-1:0] mout_norm_len;
  logic                  jbus_slot_avail;
  logic [PRI_LIM_W-1:0]  csr_jbi_debug_arb_pri_limit;
  logic                  mout_dbg_pop, mout_norm_gnt, mout_sel_dbg, mout_sel_norm, arb_busy;

  jbi_mout_dbg_arb #(
    .DBG_LEN    (DBG_LEN),
    .NORM_LEN_W (NORM_LEN_W),
    .PRI_LIM_W  (PRI_LIM_W)
  ) dut (
    .clk                         (clk),
    .rst_l                       (rst_l),
    .dbg_req_transparent         (dbg_req_transparent),
    .dbg_req_arbitrate           (dbg_req_arbitrate),
    .dbg_req_priority            (dbg_req_priority),
    .mout_norm_req               (mout_norm_req),
    .mout_norm_len               (mout_norm_len),
    .jbus_slot_avail             (jbus_slot_avail),
    .csr_jbi_debug_arb_pri_limit (csr_jbi_debug_arb_pri_limit),
    .mout_dbg_pop                (mout_dbg_pop),
    .mout_norm_gnt               (mout_norm_gnt),
    .mout_sel_dbg                (mout_sel_dbg),
    .mout_sel_norm               (mout_sel_norm),
    .arb_busy                    (arb_busy)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  bit    chk_en   = 1'b0;
  int    cyc      = 0;
  string log_s    = "";
  int    log_t[$];
  int    sd_cnt   = 0;
  int    sn_cnt   = 0;

  // Model: remaining transfer cycles of the current slot owner, plus arbitration history.
  int m_left = 0;
  bit m_last = 1'b0;
  int m_pri  = 0;
  bit e_pop = 1'b0, e_gnt = 1'b0, e_sd = 1'b0, e_sn = 1'b0;

  function automatic void chk(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endfunction

  function automatic void chk_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void chk_str(string name, string act, string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endfunction

  always @(posedge clk) begin
    int w;
    int lim;
    cyc++;
    if (!rst_l) begin
      m_left = 0; m_last = 1'b0; m_pri = 0;
      e_pop = 1'b0; e_gnt = 1'b0; e_sd = 1'b0; e_sn = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      e_pop = 1'b0; e_gnt = 1'b0;
      if (m_left == 0) begin
        e_sd = 1'b0; e_sn = 1'b0;
      end
    end else begin
      e_pop = 1'b0; e_gnt = 1'b0; e_sd = 1'b0; e_sn = 1'b0;
      if (jbus_slot_avail) begin
        lim = int'(csr_jbi_debug_arb_pri_limit);
        w = 0;  // 0 none, 1 debug, 2 normal
        if (dbg_req_priority && !(lim != 0 && m_pri == lim && mout_norm_req)) w = 1;
        else if (dbg_req_priority) w = 2;
        else if (dbg_req_arbitrate && mout_norm_req) w = m_last ? 2 : 1;
        else if (mout_norm_req) w = 2;
        else if (dbg_req_arbitrate || dbg_req_transparent) w = 1;
        if (w == 2 || !mout_norm_req) m_pri = 0;
        else if (dbg_req_priority && w == 1 && m_pri < PRI_MAX) m_pri++;
        if (w == 1) begin
          m_left = DBG_LEN; m_last = 1'b1; e_pop = 1'b1; e_sd = 1'b1;
        end else if (w == 2) begin
          m_left = int'(mout_norm_len) + 1; m_last = 1'b0; e_gnt = 1'b1; e_sn = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pop", mout_dbg_pop, e_pop);
      chk("gnt", mout_norm_gnt, e_gnt);
      chk("sel_dbg", mout_sel_dbg, e_sd);
      chk("sel_norm", mout_sel_norm, e_sn);
      chk("busy", arb_busy, e_sd | e_sn);
      if (mout_dbg_pop === 1'b1) begin log_s = {log_s, "D"}; log_t.push_back(cyc); end
      if (mout_norm_gnt === 1'b1) begin log_s = {log_s, "N"}; log_t.push_back(cyc); end
      if (mout_sel_dbg === 1'b1) sd_cnt++;
      if (mout_sel_norm === 1'b1) sn_cnt++;
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_s = "";
    log_t.delete();
    sd_cnt = 0;
    sn_cnt = 0;
  endtask

  task automatic all_idle();
    dbg_req_transparent = 1'b0; dbg_req_arbitrate = 1'b0; dbg_req_priority = 1'b0;
    mout_norm_req = 1'b0; mout_norm_len = '0; jbus_slot_avail = 1'b1;
  endtask

  initial begin
    bit only_n;
    int t0;
    rst_l = 1'b0;
    all_idle();
    csr_jbi_debug_arb_pri_limit = '0;
    run(2);
    chk_en = 1'b1;

    // Arbitrate alternation from reset: D first, gaps of DBG_LEN+1 and 2 cycles.
    dbg_req_arbitrate = 1'b1; mout_norm_req = 1'b1;
    clear_log();
    rst_l = 1'b1;
    run(12);
    chk_str("arb_alternate", log_s.substr(0, 3), "DNDN");
    if (log_t.size() >= 3) begin
      chk_int("arb_gap_dbg", log_t[1] - log_t[0], DBG_LEN + 1);
      chk_int("arb_gap_norm", log_t[2] - log_t[1], 2);
    end else begin
      chk_int("arb_grant_count", log_t.size(), 3);
    end

    // Transparent loses to normal every time.
    dbg_req_arbitrate = 1'b0; dbg_req_transparent = 1'b1;
    run(4);
    clear_log();
    run(10);
    only_n = 1'b1;
    for (int i = 0; i < log_s.len(); i++) if (log_s[i] != "N") only_n = 1'b0;
    chk("transparent_only_norm", only_n, 1'b1);
    chk_int("transparent_norm_count", log_s.len(), 5);

    // Transparent alone: one pop, sel_dbg for DBG_LEN cycles.
    all_idle();
    run(4);
    clear_log();
    dbg_req_transparent = 1'b1;
    run(1);
    dbg_req_transparent = 1'b0;
    run(5);
    chk_str("transparent_pop", log_s, "D");
    chk_int("transparent_sel_len", sd_cnt, DBG_LEN);

    // Priority limit 3: three pops then one normal grant.
    run(4);
    clear_log();
    csr_jbi_debug_arb_pri_limit = 4'd3;
    dbg_req_priority = 1'b1; mout_norm_req = 1'b1;
    run(30);
    chk_str("pri_limit3", log_s.substr(0, 7), "DDDNDDDN");

    // Unlimited priority starves normal.
    csr_jbi_debug_arb_pri_limit = '0;
    run(4);
    clear_log();
    run(30);
    only_n = 1'b0;
    for (int i = 0; i < log_s.len(); i++) if (log_s[i] == "N") only_n = 1'b1;
    chk("pri_unlimited_no_norm", only_n, 1'b0);
    chk_int("pri_unlimited_pops", log_s.len(), 10);

    // Eight-cycle normal transfer; priority raised mid-transfer waits for IDLE.
    all_idle();
    run(5);
    clear_log();
    mout_norm_req = 1'b1; mout_norm_len = 3'd7;
    run(1);
    mout_norm_req = 1'b0;
    run(2);
    dbg_req_priority = 1'b1;
    run(10);
    chk_str("long_norm_then_dbg", log_s, "ND");
    chk_int("long_norm_sel_len", sn_cnt, 8);
    if (log_t.size() == 2) chk_int("long_norm_dbg_wait", log_t[1] - log_t[0], 9);

    // Slot gating holds pri_run: two priority wins, gap, then one more before limit.
    all_idle();
    run(5);
    clear_log();
    csr_jbi_debug_arb_pri_limit = 4'd3;
    dbg_req_priority = 1'b1; mout_norm_req = 1'b1;
    run(4);
    jbus_slot_avail = 1'b0;
    run(6);
    chk_str("gate_prefix", log_s, "DD");
    clear_log();
    jbus_slot_avail = 1'b1;
    t0 = cyc;
    run(8);
    chk_str("gate_resume", log_s.substr(0, 1), "DN");
    if (log_t.size() > 0) chk_int("gate_resume_time", log_t[0], t0 + 1);

    // Reset in the middle of a debug transfer.
    all_idle();
    csr_jbi_debug_arb_pri_limit = '0;
    run(5);
    dbg_req_transparent = 1'b1;
    run(1);
    dbg_req_transparent = 1'b0;
    rst_l = 1'b0;
    run(1);
    chk("rst_pop", mout_dbg_pop, 1'b0);
    chk("rst_sel_dbg", mout_sel_dbg, 1'b0);
    chk("rst_busy", arb_busy, 1'b0);
    rst_l = 1'b1;
    clear_log();
    dbg_req_arbitrate = 1'b1; mout_norm_req = 1'b1;
    run(3);
    chk_str("rst_last_dbg_cleared", log_s.substr(0, 0), "D");

    // Randomized traffic against the model.
    all_idle();
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (mout_norm_gnt === 1'b1) mout_norm_req = 1'b0;
      if (!mout_norm_req && ($urandom % 3 == 0)) begin
        mout_norm_req = 1'b1;
        mout_norm_len = NORM_LEN_W'($urandom_range(0, 7));
      end
      if ($urandom % 4 == 0) begin
        r = $urandom_range(0, 3);
        dbg_req_transparent = (r == 1);
        dbg_req_arbitrate   = (r == 2);
        dbg_req_priority    = (r == 3);
      end
      jbus_slot_avail = ($urandom % 8 != 0);
      if ($urandom % 60 == 0) csr_jbi_debug_arb_pri_limit = PRI_LIM_W'($urandom_range(0, 4));
      rst_l = ($urandom % 400 != 0);
      run(1);
    end
    rst_l = 1'b1;
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
